// File: rtl/iter_alu_pkg.sv
// iter_alu_pkg: shared defines for the iterative ALU.
// Holds the ALUCTRL_* operation codes (including the 4'b1111 illegal code),
// the FSM state encoding and small decode helpers.
// Optional feature macro used by this slice: ITER_ALU_SHIFT4_EN.
package iter_alu_pkg;

  localparam logic [3:0] ALUCTRL_ADD     = 4'b0000;
  localparam logic [3:0] ALUCTRL_SUB     = 4'b0001;
  localparam logic [3:0] ALUCTRL_SLL     = 4'b0010;
  localparam logic [3:0] ALUCTRL_SLT     = 4'b0011;
  localparam logic [3:0] ALUCTRL_SLTU    = 4'b0100;
  localparam logic [3:0] ALUCTRL_XOR     = 4'b0101;
  localparam logic [3:0] ALUCTRL_SRL     = 4'b0110;
  localparam logic [3:0] ALUCTRL_SRA     = 4'b0111;
  localparam logic [3:0] ALUCTRL_OR      = 4'b1000;
  localparam logic [3:0] ALUCTRL_AND     = 4'b1001;
  localparam logic [3:0] ALUCTRL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Any code outside the ALUCTRL_* set (1010..1111) is illegal.
  function automatic logic is_legal(input logic [3:0] ctrl);
    return (ctrl <= ALUCTRL_AND);
  endfunction

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALUCTRL_SLL) || (ctrl == ALUCTRL_SRL) || (ctrl == ALUCTRL_SRA);
  endfunction

endpackage

// File: rtl/iter_alu_shifter.sv
// iter_alu_shifter: iterative shifter holding the data register, the 5-bit
// remaining count and the direction/arithmetic select.
// Step size is 1 bit per cycle, or up to 4 bits per cycle when
// ITER_ALU_SHIFT4_EN is defined.
module iter_alu_shifter
  import iter_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step_en,
  input  logic [3:0]  ctrl,
  input  logic [31:0] data_in,
  input  logic [4:0]  amount,
  output logic [31:0] data,
  output logic        last
);

  logic [4:0]  count;
  logic        left_q;
  logic        arith_q;
  logic [4:0]  step;
  logic [4:0]  count_nxt;
  logic [31:0] shifted;

  // Step size, next count and the shifted data for this cycle.
  always_comb begin
`ifdef ITER_ALU_SHIFT4_EN
    step = (count >= 5'd4) ? 5'd4 : count;
`else
    step = 5'd1;
`endif
    count_nxt = count - step;
    last      = (count_nxt == 5'd0);
    if (left_q) begin
      shifted = data << step;
    end else if (arith_q) begin
      shifted = $unsigned($signed(data) >>> step);
    end else begin
      shifted = data >> step;
    end
  end

  // Load on request acceptance, otherwise advance one step while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= 32'd0;
      count   <= 5'd0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      data    <= data_in;
      count   <= amount;
      left_q  <= (ctrl == ALUCTRL_SLL);
      arith_q <= (ctrl == ALUCTRL_SRA);
    end else if (step_en) begin
      data  <= shifted;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU. Single-cycle ops resolve from registered
// operands; SLL/SRL/SRA iterate in iter_alu_shifter.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds valid and payload until that edge, and
// result/illegal stay stable while out_valid is high and out_ready is low.
// Optional feature: ITER_ALU_SHIFT4_EN (4-bit shift steps, see shifter).
module iter_alu
  import iter_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        illegal,
  output logic        out_valid,
  input  logic        out_ready,
  output state_t      dbg_state
);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ctrl_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        accept;
  logic        sh_step;
  logic        sh_last;
  logic [31:0] sh_data;
  logic [31:0] alu_res;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  iter_alu_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .step_en (sh_step),
    .ctrl    (alu_ctrl),
    .data_in (op_a),
    .amount  (op_b[4:0]),
    .data    (sh_data),
    .last    (sh_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: only nonzero legal shifts visit SHIFT.
  always_comb begin
    state_nxt = state;
    sh_step   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift(alu_ctrl) && (op_b[4:0] != 5'd0)) state_nxt = ST_SHIFT;
          else                                           state_nxt = ST_DONE;
        end
      end
      ST_SHIFT: begin
        sh_step = 1'b1;
        if (sh_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request on acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
    end else if (accept) begin
      ctrl_q <= alu_ctrl;
      a_q    <= op_a;
      b_q    <= op_b;
    end
  end

  // Combinational result from the registered request.
  always_comb begin
    alu_res = 32'd0;
    case (ctrl_q)
      ALUCTRL_ADD:  alu_res = a_q + b_q;
      ALUCTRL_SUB:  alu_res = a_q - b_q;
      ALUCTRL_SLT:  alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
      ALUCTRL_SLTU: alu_res = {31'd0, (a_q < b_q)};
      ALUCTRL_XOR:  alu_res = a_q ^ b_q;
      ALUCTRL_OR:   alu_res = a_q | b_q;
      ALUCTRL_AND:  alu_res = a_q & b_q;
      ALUCTRL_SLL,
      ALUCTRL_SRL,
      ALUCTRL_SRA:  alu_res = sh_data;
      default:      alu_res = 32'd0;
    endcase
  end

  assign result  = out_valid ? alu_res : 32'd0;
  assign illegal = out_valid && !is_legal(ctrl_q);

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: bench for iter_alu (handles ITER_ALU_SHIFT4_EN builds too).
module tb_iter_alu;
  import iter_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  alu_ctrl = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] result;
  logic        illegal;
  logic        out_valid;
  logic        out_ready = 1'b0;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        exp_ill_q[$];

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[13];

  iter_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .illegal   (illegal),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions: {illegal, result}.
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (c)
      ALUCTRL_ADD:  return {1'b0, a + b};
      ALUCTRL_SUB:  return {1'b0, a - b};
      ALUCTRL_SLT:  return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
      ALUCTRL_SLTU: return {1'b0, ((a < b) ? 32'd1 : 32'd0)};
      ALUCTRL_XOR:  return {1'b0, a ^ b};
      ALUCTRL_OR:   return {1'b0, a | b};
      ALUCTRL_AND:  return {1'b0, a & b};
      ALUCTRL_SLL:  return {1'b0, a << sh};
      ALUCTRL_SRL:  return {1'b0, a >> sh};
      ALUCTRL_SRA:  return {1'b0, $unsigned($signed(a) >>> sh)};
      default:      return {1'b1, 32'd0};
    endcase
  endfunction

  // Cycles from acceptance to out_valid.
  function automatic int lat_model(input logic [3:0] c, input logic [31:0] b);
    int k;
    k = int'(b % 32);
    if (!(c == ALUCTRL_SLL || c == ALUCTRL_SRL || c == ALUCTRL_SRA) || k == 0) return 1;
`ifdef ITER_ALU_SHIFT4_EN
    return (k + 3) / 4 + 1;
`else
    return k + 1;
`endif
  endfunction

  // Driver: issue one request, wait for the response, optionally stall it.
  task automatic do_op(input string name, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [32:0] m;
    int lat;
    int busy_rdy;
    logic [31:0] er;
    logic        ei;
    logic [31:0] held;
    m = model(c, a, b);
    exp_q.push_back(m[31:0]);
    exp_ill_q.push_back(m[32]);
    @(negedge clk);
    check({name, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom_range(0, 15));
    op_a = $urandom; op_b = $urandom;
    lat = 1; busy_rdy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy++;
      @(negedge clk);
      lat++;
    end
    er = exp_q.pop_front();
    ei = exp_ill_q.pop_front();
    check({name, ".latency"}, lat, lat_model(c, b));
    check({name, ".in_ready_busy"}, busy_rdy, 0);
    check({name, ".result"}, result, er);
    check({name, ".illegal"}, {31'd0, illegal}, {31'd0, ei});
    check({name, ".in_ready_done"}, {31'd0, in_ready}, 32'd0);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, ".hold_result"}, result, held);
      check({name, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, ".released"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0] legal_codes[10];
    legal_codes = '{ALUCTRL_ADD, ALUCTRL_SUB, ALUCTRL_SLL, ALUCTRL_SLT, ALUCTRL_SLTU,
                    ALUCTRL_XOR, ALUCTRL_SRL, ALUCTRL_SRA, ALUCTRL_OR, ALUCTRL_AND};

    vecs[0]  = '{"add_wrap",  ALUCTRL_ADD,  32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0};
    vecs[1]  = '{"sub",       ALUCTRL_SUB,  32'd5,         32'd7,          32'hFFFF_FFFE,  1'b0};
    vecs[2]  = '{"slt",       ALUCTRL_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1,          1'b0};
    vecs[3]  = '{"sltu",      ALUCTRL_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0,          1'b0};
    vecs[4]  = '{"xor",       ALUCTRL_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0};
    vecs[5]  = '{"or",        ALUCTRL_OR,   32'h0000_00F0, 32'h0000_000F,  32'h0000_00FF,  1'b0};
    vecs[6]  = '{"and",       ALUCTRL_AND,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000,  1'b0};
    vecs[7]  = '{"sra31",     ALUCTRL_SRA,  32'h8000_0000, 32'd31,         32'hFFFF_FFFF,  1'b0};
    vecs[8]  = '{"srl31",     ALUCTRL_SRL,  32'h8000_0000, 32'd31,         32'h0000_0001,  1'b0};
    vecs[9]  = '{"sll4",      ALUCTRL_SLL,  32'h0000_0001, 32'd4,          32'h0000_0010,  1'b0};
    vecs[10] = '{"sll0",      ALUCTRL_SLL,  32'h0000_0003, 32'h0000_0020,  32'h0000_0003,  1'b0};
    vecs[11] = '{"sra16",     ALUCTRL_SRA,  32'h7FFF_0000, 32'd16,         32'h0000_7FFF,  1'b0};
    vecs[12] = '{"illegal",   ALUCTRL_ILLEGAL, 32'd123,    32'd456,        32'h0,          1'b1};

    // Reset: values must appear without any clock edge.
    #1;
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.illegal", {31'd0, illegal}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: expected values in the table are hand-derived; the
    // model is checked against them too.
    for (int i = 0; i < 13; i++) begin
      logic [32:0] m;
      m = model(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      check({vecs[i].name, ".model"}, m[31:0], vecs[i].exp_res);
      do_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, 0);
    end

    // Unlisted code 4'b1010 is also illegal.
    do_op("illegal_1010", 4'b1010, 32'hDEAD_BEEF, 32'h1, 0);

    // Output stall: out_ready low for 5 cycles in DONE.
    do_op("hold_add", ALUCTRL_ADD, 32'h1234_5678, 32'h1111_1111, 5);
    do_op("hold_srl", ALUCTRL_SRL, 32'hF000_0000, 32'd7, 5);

    // Reset in the middle of SLL by 20.
    begin
      int seen;
      @(negedge clk);
      alu_ctrl = ALUCTRL_SLL; op_a = 32'h1; op_b = 32'd20; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst.shifting", {30'd0, dbg_state}, {30'd0, ST_SHIFT});
      rst_n = 1'b0;
      #1;
      check("midrst.in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst.result", result, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst.no_output", seen, 0);
      check("midrst.idle_ready", {31'd0, in_ready}, 32'd1);
    end

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                      : legal_codes[$urandom_range(0, 9)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      do_op("rand", c, a, b, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
